// File: rtl/ipv4_rx.sv
// IPv4 receive header stage: validates the 20-byte header, strips it and forwards the
// payload truncated to total_length; rejected or cancelled packets are dropped whole.
module ipv4_rx #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int HEAD_N = 20
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic              cancel_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o,
  output logic [7:0]        proto_o,
  output logic              hdr_err_o
);

  localparam int WORD_N = DATA_W / 16;

  typedef enum logic [1:0] {IDLE, HEAD, DATA, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       rem_q, rem_d;
  logic [16:0]       sum_q, sum_d;
  logic [7:0]        vihl_q, vihl_d;
  logic [15:0]       tlen_q, tlen_d;
  logic [7:0]        prot_hdr_q, prot_hdr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              cancel_q, cancel_d;
  logic              err_q, err_d;
  logic [7:0]        proto_q, proto_d;

  logic [15:0]       word_w [WORD_N];
  logic [17:0]       acc;
  logic [16:0]       sum_next;
  logic [15:0]       nbytes;
  logic [KEEP_W-1:0] rem_mask;
  logic              hdr_beat;
  logic              last_hdr;
  logic              hdr_ok;

  // Final fold of a 17-bit partial sum; two passes cover the carry of the first.
  function automatic logic [15:0] fold17(input logic [16:0] x);
    logic [16:0] y;
    y = {1'b0, x[15:0]} + {16'd0, x[16]};
    return y[15:0] + {15'd0, y[16]};
  endfunction

  generate
    for (genvar gi = 0; gi < WORD_N; gi++) begin : g_word
      assign word_w[gi] = {data_i[16*gi +: 8], data_i[16*gi+8 +: 8]};
    end
  endgenerate

  always_comb begin
    acc = {2'b00, sum_q[15:0]} + {17'd0, sum_q[16]};
    for (int w = 0; w < WORD_N; w++) begin
      acc = acc + {2'b00, word_w[w]};
    end
    sum_next = {1'b0, acc[15:0]} + {15'd0, acc[17:16]};
  end

  assign hdr_beat = valid_i && !cancel_i && (state_q == IDLE || state_q == HEAD);
  assign last_hdr = (cnt_q + 8'(KEEP_W)) == 8'(HEAD_N);

  always_comb begin
    vihl_d     = vihl_q;
    tlen_d     = tlen_q;
    prot_hdr_d = prot_hdr_q;
    if (hdr_beat) begin
      for (int b = 0; b < KEEP_W; b++) begin
        case (cnt_q + 8'(b))
          8'd0:    vihl_d       = data_i[8*b +: 8];
          8'd2:    tlen_d[15:8] = data_i[8*b +: 8];
          8'd3:    tlen_d[7:0]  = data_i[8*b +: 8];
          8'd9:    prot_hdr_d   = data_i[8*b +: 8];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    nbytes   = '0;
    rem_mask = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      nbytes      = nbytes + 16'(keep_i[b]);
      rem_mask[b] = rem_q > 16'(b);
    end
  end

  assign hdr_ok = (vihl_d[7:4] == 4'd4) && (vihl_d[3:0] == 4'd5) &&
                  (fold17(sum_next) == 16'hFFFF) && (tlen_d >= 16'(HEAD_N));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    valid_d  = 1'b0;
    data_d   = '0;
    keep_d   = '0;
    last_d   = 1'b0;
    cancel_d = 1'b0;
    err_d    = 1'b0;
    proto_d  = proto_q;
    if (cancel_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sum_d    = '0;
      rem_d    = '0;
      cancel_d = (state_q == DATA);
    end else begin
      case (state_q)
        IDLE, HEAD: begin
          if (valid_i) begin
            state_d = HEAD;
            cnt_d   = cnt_q + 8'(KEEP_W);
            sum_d   = sum_next;
            if (last_hdr) begin
              cnt_d = '0;
              sum_d = '0;
              if (hdr_ok) begin
                proto_d = prot_hdr_d;
                rem_d   = tlen_d - 16'(HEAD_N);
                state_d = (tlen_d == 16'(HEAD_N)) ? DRAIN : DATA;
              end else begin
                err_d   = 1'b1;
                state_d = DRAIN;
              end
            end
          end
        end
        DATA: begin
          if (valid_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            if (rem_q <= nbytes) begin
              keep_d  = keep_i & rem_mask;
              last_d  = 1'b1;
              rem_d   = '0;
              state_d = DRAIN;
            end else begin
              rem_d = rem_q - nbytes;
              // A short beat before the length is exhausted ends a truncated packet.
              if (nbytes < 16'(KEEP_W)) begin
                last_d  = 1'b1;
                state_d = DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (!valid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      sum_q      <= '0;
      vihl_q     <= '0;
      tlen_q     <= '0;
      prot_hdr_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      cancel_q   <= 1'b0;
      err_q      <= 1'b0;
      proto_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      sum_q      <= sum_d;
      vihl_q     <= vihl_d;
      tlen_q     <= tlen_d;
      prot_hdr_q <= prot_hdr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      cancel_q   <= cancel_d;
      err_q      <= err_d;
      proto_q    <= proto_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign keep_o    = keep_q;
  assign last_o    = last_q;
  assign cancel_o  = cancel_q;
  assign hdr_err_o = err_q;
  assign proto_o   = proto_q;

endmodule
